// File: rtl/multiplexer_scan_pkg.sv
// Shared types and constants for the 4:1 multiplexer scan controller.
package multiplexer_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } scan_state_t;

    localparam int SCAN_CHANNELS = 4;
    localparam int SEL_W         = 2;
    localparam int SETTLE_W      = 4;

    localparam logic [SEL_W-1:0] LAST_CHANNEL = SEL_W'(SCAN_CHANNELS - 1);

    // Lowest enabled channel at or above lo; MSB of the result flags a hit.
    function automatic logic [SEL_W:0] first_enabled(input logic [SCAN_CHANNELS-1:0] mask,
                                                     input int lo);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = SCAN_CHANNELS - 1; i >= 0; i--) begin
            if (i >= lo && mask[i]) r = {1'b1, SEL_W'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/multiplexer_scan_controller_settle_timer.sv
// Loadable settle down-counter; zero flags that the mux output may be sampled.
module multiplexer_scan_settle_timer
    import multiplexer_scan_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_value,
    output logic                zero
);

    logic [SETTLE_W-1:0] count;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                count <= '0;
        else if (load)          count <= load_value;
        else if (count != '0)   count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/multiplexer_scan_controller.sv
// Steps a 4:1 mux through its inputs, samples f after a settle time and
// presents the assembled word with valid/ready.
// Optional feature: define MULTIPLEXER_SCAN_MASK_EN to add channel_mask,
// which skips disabled channels (their result bits read 0).
//
// state  | meaning
// IDLE   | select 00, waiting for start
// SETTLE | holding select on current channel until the timer expires, then sample f
// DONE   | result valid on data_out, select parked at 11, waiting for ready
module multiplexer_scan_controller
    import multiplexer_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     f,
    output logic                     s0,
    output logic                     s1,
    output logic [SCAN_CHANNELS-1:0] data_out,
    output logic                     valid,
    input  logic                     ready,
`ifdef MULTIPLEXER_SCAN_MASK_EN
    input  logic [SCAN_CHANNELS-1:0] channel_mask,
`endif
    output logic                     busy
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

    scan_state_t              state, next_state;
    logic [SEL_W-1:0]         channel;
    logic [SCAN_CHANNELS-1:0] shadow, shadow_cap;
    logic [SCAN_CHANNELS-1:0] start_mask, scan_mask;
    logic [SEL_W:0]           pick;
    logic                     timer_load, timer_zero;

`ifdef MULTIPLEXER_SCAN_MASK_EN
    logic [SCAN_CHANNELS-1:0] mask_q;
    assign start_mask = channel_mask;
    assign scan_mask  = mask_q;

    // Mask is frozen for the whole scan at the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          mask_q <= '0;
        else if (state == IDLE && start)  mask_q <= channel_mask;
    end
`else
    assign start_mask = '1;
    assign scan_mask  = '1;
`endif

    multiplexer_scan_settle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (SETTLE_LOAD),
        .zero       (timer_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state, timer reload and next-channel selection.
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        pick       = '0;
        case (state)
            IDLE: begin
                pick = first_enabled(start_mask, 0);
                if (start) begin
                    timer_load = pick[SEL_W];
                    next_state = pick[SEL_W] ? SETTLE : DONE;
                end
            end
            SETTLE: begin
                pick = first_enabled(scan_mask, int'(channel) + 1);
                if (timer_zero) begin
                    timer_load = pick[SEL_W];
                    if (!pick[SEL_W]) next_state = DONE;
                end
            end
            DONE: begin
                if (ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Shadow word with the current channel's sample merged in.
    always_comb begin
        shadow_cap          = shadow;
        shadow_cap[channel] = f;
    end

    // Channel stepping, shadow capture and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            channel  <= '0;
            shadow   <= '0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow  <= '0;
                        channel <= pick[SEL_W] ? pick[SEL_W-1:0] : LAST_CHANNEL;
                        if (!pick[SEL_W]) data_out <= '0;
                    end
                end
                SETTLE: begin
                    if (timer_zero) begin
                        shadow <= shadow_cap;
                        if (pick[SEL_W]) begin
                            channel <= pick[SEL_W-1:0];
                        end else begin
                            channel  <= LAST_CHANNEL;
                            data_out <= shadow_cap;
                        end
                    end
                end
                DONE: begin
                    if (ready) channel <= '0;
                end
                default: ;
            endcase
        end
    end

    assign {s1, s0} = channel;
    assign valid    = (state == DONE);
    assign busy     = (state != IDLE);

endmodule

// File: doc/multiplexer_scan_controller.md
# multiplexer_scan_controller

Sequencing stage that sits directly upstream of a 4:1 multiplexer: it drives the select lines `s1`/`s0`, waits a programmable settle time, samples the mux output `f`, and steps through all four inputs. The four sampled bits are assembled into a parallel word and presented downstream with a valid/ready handshake. It turns a static 4:1 mux into a 4-channel serial-to-parallel scanner.

## Interface
- `SETTLE_CYCLES`, default 1: extra cycles each select value is held before `f` is sampled (0..15).
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a scan; honoured only in IDLE.
- `f` input 1: mux output being sampled.
- `s0` output 1: select LSB to mux.
- `s1` output 1: select MSB to mux.
- `data_out` output 4: scan result, bit k = `f` sampled with select = k.
- `valid` output 1: `data_out` holds a completed scan.
- `ready` input 1: downstream accepts `data_out`.
- `busy` output 1: high in any state other than IDLE.
- `channel_mask` input 4: present only with `MULTIPLEXER_SCAN_MASK_EN`; see Configuration.

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE:
  - `s1,s0` = 00; `valid` = 0; `busy` = 0.
  - `start`=1 at an edge enters SETTLE with channel = first enabled channel and settle counter = `SETTLE_CYCLES`.
- SETTLE:
  - `{s1,s0}` = current channel index.
  - Counter decrements each cycle.
  - At the edge where the counter is 0, `f` is captured into shadow bit [channel], and the FSM then does one of the following:
    - Advances to the next enabled channel and reloads the counter.
    - After channel 3, copies the shadow word to `data_out` and enters DONE.
- DONE:
  - `valid` = 1 and `data_out` is stable.
  - `{s1,s0}` holds 11, the last channel.
  - An edge with `ready`=1 returns the FSM to IDLE; `valid` drops.
- Shadow word is cleared on scan start. `data_out` changes only on entry to DONE and retains the last result in IDLE.
- `start` outside IDLE is ignored. `start` and `ready` together in DONE only return to IDLE; no back-to-back restart.
- Reset values, asynchronous and applied immediately at any time including mid-scan:
  - State IDLE.
  - `s0`=`s1`=0.
  - `data_out`=0000.
  - `valid`=0.
  - `busy`=0.
  - Counter and channel = 0.

## Timing
- All outputs are registered. `s0`/`s1` change only on clock edges.
- `start` sampled at edge E0 gives:
  - Channel k selected from E0 (k=0) or from the previous sample edge.
  - Channel k sampled at edge E0 + (k+1)·(`SETTLE_CYCLES`+1).
- `valid` rises after edge E0 + 4·(`SETTLE_CYCLES`+1): 8 cycles with default, 4 cycles with `SETTLE_CYCLES`=0.
- Minimum `valid` pulse: 1 cycle (`ready` already high). `ready`/`valid` handshake completes on the edge where both are 1.
- `f` must be stable from (sample edge − `SETTLE_CYCLES` cycles) through the sample edge. Mux propagation budget = `SETTLE_CYCLES`+1 clock periods.

## Configuration
- `MULTIPLEXER_SCAN_MASK_EN` defined:
  - `channel_mask` port exists and is sampled at the `start` edge.
  - Channels with mask bit 0 are skipped in zero cycles and their `data_out` bit reads 0.
  - Mask 0000 goes from IDLE to DONE in one edge with `data_out`=0000.
  - Latency = (enabled count)·(`SETTLE_CYCLES`+1).
- Not defined: no `channel_mask` port; all four channels are always scanned. Timing is as stated above.

## Structure
- Package `multiplexer_scan_pkg`:
  - State enum typedef (IDLE/SETTLE/DONE).
  - `SCAN_CHANNELS` = 4.
  - `SEL_W` = 2.
  - Counter width constant `SETTLE_W` = 4.
- One sub-module, `multiplexer_scan_settle_timer`: loadable down-counter with `load`, `load_value`, and `zero` flag. The FSM, channel stepping and shadow register stay in the top.
- The 4:1 mux itself is instantiated by the parent, not inside this block.

## Test plan
- Reset mid-scan: assert `rst` two cycles after `start` → `s0`/`s1`/`valid`/`busy`/`data_out` = 0 immediately. Next `start` scans normally.
- Default timing, mux inputs 1,0,1,1 (i0..i3), `ready`=1: pulse `start` → selects step 00,01,10,11 every 2 cycles. `valid` is high 8 cycles after the start edge for 1 cycle, `data_out`=4'b1101.
- Backpressure, `SETTLE_CYCLES`=0, inputs 0,1,1,0, `ready`=0: `data_out`=4'b0110 and `valid` hold for 10 cycles. `start` pulses during DONE are ignored. `ready`=1 → IDLE next edge.
- Settle check, `SETTLE_CYCLES`=3, with `f` glitching during the first 3 cycles of each select: glitches are never captured, and `valid` arrives 16 cycles after start.
- Mask, with `MULTIPLEXER_SCAN_MASK_EN` and `SETTLE_CYCLES`=1:
  - Mask 4'b1010, all inputs 1 → only channels 1 and 3 selected; `data_out`=4'b1010 after 4 cycles.
  - Mask 0000 → `valid` one edge after start, `data_out`=0000.
